// File: rtl/proc_control_unit_pkg.sv
// Shared encodings for the accumulator processor control unit: FSM states,
// opcodes, ALU and write-back selector codes, plus opcode classification helpers.
package proc_pkg;

  localparam int         OPC_W            = 4;
  localparam logic [3:0] DEF_ACC_ADDR     = 4'hF;
  localparam int         DEF_WAIT_LIMIT   = 255;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC   = 4'd2,
    MEM_RD = 4'd3,
    MEM_WR = 4'd4,
    WB_ACC = 4'd5,
    WB_REG = 4'd6,
    BRANCH = 4'd7,
    HALT   = 4'd8
  } state_e;

  localparam logic [OPC_W-1:0] OP_ADD  = 4'h0;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'h1;
  localparam logic [OPC_W-1:0] OP_AND  = 4'h2;
  localparam logic [OPC_W-1:0] OP_OR   = 4'h3;
  localparam logic [OPC_W-1:0] OP_LW   = 4'h4;
  localparam logic [OPC_W-1:0] OP_SW   = 4'h5;
  localparam logic [OPC_W-1:0] OP_BEQZ = 4'h6;
  localparam logic [OPC_W-1:0] OP_J    = 4'h7;
  localparam logic [OPC_W-1:0] OP_LI   = 4'h8;
  localparam logic [OPC_W-1:0] OP_MOV  = 4'h9;
  localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_PASSB = 3'd7;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_IMM = 2'd2;
  localparam logic [1:0] WB_A   = 2'd3;

  function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  // Successor of DECODE; undefined opcodes fall back to FETCH.
  function automatic state_e dispatch(input logic [OPC_W-1:0] op);
    state_e nxt;
    if (is_alu_op(op)) begin
      nxt = EXEC;
    end else begin
      case (op)
        OP_LW:             nxt = MEM_RD;
        OP_SW:             nxt = MEM_WR;
        OP_BEQZ, OP_J:     nxt = BRANCH;
        OP_LI:             nxt = WB_ACC;
        OP_MOV:            nxt = WB_REG;
        OP_HALT:           nxt = HALT;
        default:           nxt = FETCH;
      endcase
    end
    return nxt;
  endfunction

  function automatic logic is_illegal(input logic [OPC_W-1:0] op);
    return !is_alu_op(op) && (op != OP_LW) && (op != OP_SW) && (op != OP_BEQZ) &&
           (op != OP_J) && (op != OP_LI) && (op != OP_MOV) && (op != OP_HALT);
  endfunction

endpackage

// File: rtl/proc_control_unit_mem_wait_timer.sv
// Saturating 8-bit wait counter for the memory req/ack handshake; flags a
// timeout in the cycle whose increment would bring the count to the limit.
module mem_wait_timer #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ack,
  input  logic clear,
  output logic timeout
);

  localparam logic [7:0] LAST_WAIT = 8'(WAIT_LIMIT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: cleared on ack or state change, otherwise counts unacked requests.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || (req && ack)) begin
      cnt_d = 8'd0;
    end else if (req && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // An ack in the final cycle suppresses the timeout.
  assign timeout = req && !ack && (cnt_q == LAST_WAIT);

endmodule

// File: rtl/proc_control_unit.sv
// Multi-cycle control FSM for the 16-bit accumulator processor: sequences
// fetch/decode/execute/write-back and drives every datapath strobe.
module proc_control_unit
  import proc_pkg::*;
#(
  parameter logic [3:0] ACC_ADDR   = DEF_ACC_ADDR,
  parameter int         WAIT_LIMIT = DEF_WAIT_LIMIT
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [OPC_W-1:0] Opcode,
  input  logic [3:0]       Reg_Field,
  input  logic             Is_Zero,
  input  logic             Mem_Ack,
  output logic             IR_Write,
  output logic             PC_Write,
  output logic             PC_Src,
  output logic             Awrite,
  output logic             Bwrite,
  output logic             ALUOut_Write,
  output logic [2:0]       ALU_Op,
  output logic             reg_write,
  output logic [3:0]       write_address,
  output logic [1:0]       WB_Src,
  output logic             iszero_write,
  output logic             Mem_Read,
  output logic             Mem_Write,
  output logic             Illegal,
  output logic             Bus_Error,
  output logic             Halted
);

  state_e           state_q, state_d;
  logic [OPC_W-1:0] op_q, op_d;
  logic [3:0]       rf_q, rf_d;
  logic             bus_err_q, bus_err_d;
  logic             req_s;
  logic             timeout_s;

  assign req_s = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);

  mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait (
    .clk     (Clock),
    .rst_n   (Reset_n),
    .req     (req_s),
    .ack     (Mem_Ack),
    .clear   (state_d != state_q),
    .timeout (timeout_s)
  );

  // Next-state logic; opcode and register field are captured only in DECODE.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rf_d      = rf_q;
    bus_err_d = bus_err_q;
    case (state_q)
      FETCH, MEM_RD, MEM_WR: begin
        if (Mem_Ack) begin
          state_d = (state_q == FETCH)  ? DECODE :
                    (state_q == MEM_RD) ? WB_ACC : FETCH;
        end else if (timeout_s) begin
          state_d   = HALT;
          bus_err_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      DECODE: begin
        op_d    = Opcode;
        rf_d    = Reg_Field;
        state_d = dispatch(Opcode);
      end
      EXEC:                   state_d = WB_ACC;
      WB_ACC, WB_REG, BRANCH: state_d = FETCH;
      HALT:                   state_d = HALT;
      default:                state_d = FETCH;
    endcase
  end

  // State and latched-instruction registers.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q   <= FETCH;
      op_q      <= {OPC_W{1'b0}};
      rf_q      <= 4'd0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rf_q      <= rf_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Output decode of the registered state; everything is held low during reset.
  always_comb begin
    IR_Write      = 1'b0;
    PC_Write      = 1'b0;
    PC_Src        = 1'b0;
    Awrite        = 1'b0;
    Bwrite        = 1'b0;
    ALUOut_Write  = 1'b0;
    ALU_Op        = ALU_ADD;
    reg_write     = 1'b0;
    write_address = 4'd0;
    WB_Src        = WB_ALU;
    iszero_write  = 1'b0;
    Mem_Read      = 1'b0;
    Mem_Write     = 1'b0;
    Illegal       = 1'b0;
    Bus_Error     = 1'b0;
    Halted        = 1'b0;
    if (!Reset_n) begin
      Bus_Error = 1'b0;
    end else begin
      Bus_Error = bus_err_q;
      case (state_q)
        FETCH: begin
          Mem_Read = 1'b1;
          IR_Write = Mem_Ack;
          PC_Write = Mem_Ack;
          PC_Src   = 1'b0;
        end
        DECODE: begin
          Awrite  = 1'b1;
          Bwrite  = 1'b1;
          Illegal = is_illegal(Opcode);
        end
        EXEC: begin
          ALUOut_Write = 1'b1;
          ALU_Op       = op_q[2:0];
        end
        MEM_RD: Mem_Read  = 1'b1;
        MEM_WR: Mem_Write = 1'b1;
        WB_ACC: begin
          reg_write     = 1'b1;
          write_address = ACC_ADDR;
          iszero_write  = 1'b1;
          WB_Src        = (op_q == OP_LW) ? WB_MEM :
                          (op_q == OP_LI) ? WB_IMM : WB_ALU;
        end
        WB_REG: begin
          reg_write     = 1'b1;
          write_address = rf_q;
          WB_Src        = WB_A;
        end
        BRANCH: begin
          PC_Src   = 1'b1;
          PC_Write = (op_q == OP_J) ? 1'b1 : Is_Zero;
        end
        HALT:    Halted = 1'b1;
        default: Halted = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_control_unit.sv
// Randomized scoreboard bench for proc_control_unit: a per-instruction model
// queues the expected output of every cycle and a negedge monitor checks them.
module tb_proc_control_unit;

  logic       Clock = 1'b0;
  logic       Reset_n, Is_Zero, Mem_Ack;
  logic [3:0] Opcode, Reg_Field;
  logic       IR_Write, PC_Write, PC_Src, Awrite, Bwrite, ALUOut_Write;
  logic [2:0] ALU_Op;
  logic       reg_write;
  logic [3:0] write_address;
  logic [1:0] WB_Src;
  logic       iszero_write, Mem_Read, Mem_Write, Illegal, Bus_Error, Halted;

  proc_control_unit dut (
    .Clock(Clock), .Reset_n(Reset_n), .Opcode(Opcode), .Reg_Field(Reg_Field),
    .Is_Zero(Is_Zero), .Mem_Ack(Mem_Ack), .IR_Write(IR_Write), .PC_Write(PC_Write),
    .PC_Src(PC_Src), .Awrite(Awrite), .Bwrite(Bwrite), .ALUOut_Write(ALUOut_Write),
    .ALU_Op(ALU_Op), .reg_write(reg_write), .write_address(write_address),
    .WB_Src(WB_Src), .iszero_write(iszero_write), .Mem_Read(Mem_Read),
    .Mem_Write(Mem_Write), .Illegal(Illegal), .Bus_Error(Bus_Error), .Halted(Halted)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic       ir_write, pc_write, pc_src, awrite, bwrite, aluout_write;
    logic [2:0] alu_op;
    logic       reg_write;
    logic [3:0] waddr;
    logic [1:0] wb_src;
    logic       iszero_write, mem_read, mem_write, illegal, bus_error, halted;
  } ov_t;

  typedef struct {
    ov_t   e;
    ov_t   m;
    string tag;
  } item_t;

  item_t sb_q[$];
  item_t mon_it;
  int    total = 0;
  int    bad = 0;
  bit    bus_err = 1'b0;
  ov_t   act;

  assign act = {IR_Write, PC_Write, PC_Src, Awrite, Bwrite, ALUOut_Write, ALU_Op,
                reg_write, write_address, WB_Src, iszero_write, Mem_Read,
                Mem_Write, Illegal, Bus_Error, Halted};

  // Monitor: one expected output vector per cycle, compared under its care-mask.
  always @(negedge Clock) begin
    if (sb_q.size() > 0) begin
      mon_it = sb_q.pop_front();
      total++;
      if (((act ^ mon_it.e) & mon_it.m) != '0) begin
        bad++;
        $display("FAIL %s t=%0t actual=%b expected=%b care=%b",
                 mon_it.tag, $time, act, mon_it.e, mon_it.m);
      end
    end
  end

  function automatic logic r1();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] r4();
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic ov_t base();
    ov_t e = '0;
    e.bus_error = bus_err;
    return e;
  endfunction

  // Drive one cycle of inputs and queue what the outputs must be in that cycle.
  task automatic cyc(input string tag, input ov_t e, input logic rstn, input logic ack,
                     input logic iz, input logic [3:0] op, input logic [3:0] rf,
                     input bit full);
    item_t it;
    ov_t   m;
    @(posedge Clock);
    #1;
    Reset_n = rstn; Mem_Ack = ack; Is_Zero = iz; Opcode = op; Reg_Field = rf;
    m = '1;
    if (!full) begin
      if (!e.pc_write) m.pc_src = 1'b0;
      if (!e.reg_write) begin m.waddr = 4'd0; m.wb_src = 2'd0; end
      if (!e.aluout_write) m.alu_op = 3'd0;
    end
    it.e = e; it.m = m; it.tag = tag;
    sb_q.push_back(it);
  endtask

  task automatic rst_cycle(input logic ack);
    cyc("reset", '0, 1'b0, ack, r1(), r4(), r4(), 1'b1);
    bus_err = 1'b0;
  endtask

  task automatic wb_acc(input logic [1:0] src);
    ov_t e = base();
    e.reg_write = 1'b1; e.waddr = 4'hF; e.wb_src = src; e.iszero_write = 1'b1;
    cyc("wb_acc", e, 1'b1, r1(), r1(), r4(), r4(), 1'b0);
  endtask

  // Waiting cycles then the ack cycle of one memory request.
  task automatic mem_req(input string tag, input bit wr, input int waits);
    ov_t e = base();
    e.mem_read = !wr; e.mem_write = wr;
    for (int i = 0; i < waits; i++) cyc({tag, "_wait"}, e, 1'b1, 1'b0, r1(), r4(), r4(), 1'b0);
    cyc({tag, "_ack"}, e, 1'b1, 1'b1, r1(), r4(), r4(), 1'b0);
  endtask

  // Whole instruction from FETCH entry, with fd fetch waits and md data waits.
  task automatic instr(input logic [3:0] op, input logic [3:0] rf, input logic iz,
                       input int fd, input int md);
    ov_t e;
    e = base(); e.mem_read = 1'b1;
    for (int i = 0; i < fd; i++) cyc("fetch_wait", e, 1'b1, 1'b0, r1(), r4(), r4(), 1'b0);
    e.ir_write = 1'b1; e.pc_write = 1'b1; e.pc_src = 1'b0;
    cyc("fetch_ack", e, 1'b1, 1'b1, r1(), r4(), r4(), 1'b0);
    e = base(); e.awrite = 1'b1; e.bwrite = 1'b1;
    e.illegal = (op >= 4'hA) && (op <= 4'hE);
    cyc("decode", e, 1'b1, r1(), r1(), op, rf, 1'b0);
    if (op <= 4'd3) begin
      e = base(); e.aluout_write = 1'b1; e.alu_op = op[2:0];
      cyc("exec", e, 1'b1, r1(), r1(), r4(), r4(), 1'b0);
      wb_acc(2'd0);
    end else if (op == 4'd4) begin
      mem_req("mem_rd", 1'b0, md);
      wb_acc(2'd1);
    end else if (op == 4'd5) begin
      mem_req("mem_wr", 1'b1, md);
    end else if (op == 4'd6 || op == 4'd7) begin
      e = base(); e.pc_src = 1'b1; e.pc_write = (op == 4'd7) || iz;
      cyc("branch", e, 1'b1, r1(), iz, r4(), r4(), 1'b0);
    end else if (op == 4'd8) begin
      wb_acc(2'd2);
    end else if (op == 4'd9) begin
      e = base(); e.reg_write = 1'b1; e.waddr = rf; e.wb_src = 2'd3;
      cyc("wb_reg", e, 1'b1, r1(), r1(), r4(), r4(), 1'b0);
    end else begin
      e = base();
    end
  endtask

  task automatic halt_cycles(input int n);
    ov_t e = base();
    e.halted = 1'b1;
    for (int i = 0; i < n; i++) cyc("halted", e, 1'b1, r1(), r1(), r4(), r4(), 1'b0);
  endtask

  initial begin
    ov_t e;
    int  waits;
    Reset_n = 1'b0; Mem_Ack = 1'b1; Is_Zero = 1'b0; Opcode = 4'd0; Reg_Field = 4'd0;

    rst_cycle(1'b1);
    rst_cycle(1'b1);

    instr(4'h0, r4(), r1(), 0, 0);
    instr(4'h4, r4(), r1(), 0, 3);
    instr(4'h6, r4(), 1'b0, 0, 0);
    instr(4'h6, r4(), 1'b1, 0, 0);
    instr(4'hB, r4(), r1(), 0, 0);
    instr(4'h1, r4(), r1(), 254, 0);
    instr(4'h4, r4(), r1(), 0, 254);
    instr(4'h5, r4(), r1(), 2, 254);

    for (int n = 0; n < 250; n++) begin
      instr(4'($urandom_range(0, 14)), r4(), r1(),
            ($urandom_range(0, 9) == 0) ? $urandom_range(3, 20) : $urandom_range(0, 2),
            ($urandom_range(0, 9) == 0) ? $urandom_range(3, 20) : $urandom_range(0, 2));
    end

    instr(4'hF, r4(), r1(), 1, 0);
    halt_cycles(20);

    // Reset while a fetch request is pending, then starve FETCH into a timeout.
    rst_cycle(1'b0);
    e = base(); e.mem_read = 1'b1;
    cyc("fetch_wait", e, 1'b1, 1'b0, r1(), r4(), r4(), 1'b0);
    cyc("fetch_wait", e, 1'b1, 1'b0, r1(), r4(), r4(), 1'b0);
    rst_cycle(1'b0);
    for (int i = 0; i < 255; i++) cyc("timeout_wait", e, 1'b1, 1'b0, r1(), r4(), r4(), 1'b0);
    bus_err = 1'b1;
    halt_cycles(5);
    rst_cycle(1'b0);
    instr(4'h9, r4(), r1(), 0, 0);
    waits = 0;
    instr(4'h8, r4(), r1(), waits, 0);

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge Clock);
    #1;
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain actual=%0d expected=0 (items left)", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/proc_control_unit.md
Name: proc_control_unit

Overview:
- Multi-cycle control FSM for the 16-bit multi-register accumulator processor.
- It is the initiator side of the datapath strobe interface. It generates, in the correct cycle order, every write enable the datapath responds to: IR_Write, Awrite, Bwrite, reg_write, iszero_write, PC/ALUOut writes and memory requests.
- It decodes the opcode from IR, sequences fetch, decode, execute and writeback, and runs a req/ack handshake with memory that includes a timeout.

Parameters:
- OPC_W, 4, opcode width (IR[15:12]).
- ACC_ADDR, 4'hF, register-file address of the accumulator.
- WAIT_LIMIT, 255, maximum number of cycles to wait for Mem_Ack before declaring a bus error.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset_n  in  1  synchronous active-low reset.
- Opcode  in  4  IR[15:12] from the datapath.
- Reg_Field  in  4  IR[11:8], register operand.
- Is_Zero  in  1  accumulator-zero flag from the datapath.
- Mem_Ack  in  1  memory completion; valid only while a request is high.
- IR_Write  out  1  load IR from Data_In.
- PC_Write  out  1  load PC.
- PC_Src  out  1  0 = PC+2, 1 = branch/jump target.
- Awrite  out  1  load A from ACC.
- Bwrite  out  1  load B from Reg[Reg_Field].
- ALUOut_Write  out  1  load ALUOut.
- ALU_Op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 7 pass-B.
- reg_write  out  1  register-file write strobe.
- write_address  out  4  register-file write address.
- WB_Src  out  2  0 ALUOut, 1 memory data, 2 immediate, 3 A.
- iszero_write  out  1  update the zero flag.
- Mem_Read  out  1  read request.
- Mem_Write  out  1  write request.
- Illegal  out  1  one-cycle pulse on an undefined opcode.
- Bus_Error  out  1  sticky; set on memory timeout.
- Halted  out  1  high in the HALT state.

Behaviour:
- Single clock. Reset is synchronous and active-low: a Clock edge with Reset_n=0 moves the state to FETCH, clears the wait counter and clears Bus_Error.
- While Reset_n=0, every strobe and request output is forced to 0, write_address=0 and ALU_Op=0. Reset asserted mid-transaction drops Mem_Read/Mem_Write in the same cycle.
- Outputs are combinational decodes of the registered state plus the latched opcode, which is captured in DECODE. Opcode changes outside DECODE have no effect.
- Opcodes:
  - 0–3: ALU ops.
  - 4: LW.
  - 5: SW.
  - 6: BEQZ.
  - 7: J.
  - 8: LI.
  - 9: MOV (ACC to Reg_Field).
  - F: HALT.
  - Anything else is illegal.
- FETCH:
  - Mem_Read=1.
  - When Mem_Ack=1: IR_Write=1, PC_Write=1, PC_Src=0, then go to DECODE.
  - A zero-wait ack (same cycle as the request) is legal, so FETCH can take a single cycle.
- DECODE:
  - Awrite=1 and Bwrite=1.
  - Dispatch: ALU ops to EXEC; LW to MEM_RD; SW to MEM_WR; BEQZ/J to BRANCH; LI to WB_ACC; MOV to WB_REG; HALT to HALT.
  - Illegal opcode: Illegal=1 for this cycle, then FETCH.
- EXEC: ALUOut_Write=1, ALU_Op from the opcode, then WB_ACC.
- WB_ACC:
  - reg_write=1, write_address=ACC_ADDR, iszero_write=1, then FETCH.
  - WB_Src: 0 after EXEC, 1 after LW, 2 for LI.
- WB_REG: reg_write=1, write_address=Reg_Field (latched in DECODE), WB_Src=3, iszero_write=0, then FETCH.
- MEM_RD: Mem_Read=1, held until Mem_Ack, then WB_ACC with WB_Src=1.
- MEM_WR: Mem_Write=1, held until Mem_Ack, then FETCH.
- Memory handshake rules:
  - A request stays high and stable until Mem_Ack is sampled high.
  - A new request is never issued in the ack cycle.
  - Mem_Read and Mem_Write are never both high.
- BRANCH, one cycle, then FETCH:
  - J: PC_Write=1, PC_Src=1.
  - BEQZ: PC_Write=Is_Zero (sampled this cycle), PC_Src=1.
- HALT: Halted=1, all strobes 0; the FSM leaves HALT only on reset.
- Wait counter (8-bit, saturating):
  - Increments in each cycle that a request is high and Mem_Ack=0; clears on ack and on any state change.
  - When the count reaches WAIT_LIMIT with no ack: Bus_Error set (sticky), request dropped, next state HALT.
  - An ack arriving in that same cycle wins over the timeout.
- Latency, counted from FETCH entry with zero-wait memory:
  - ALU op: 4 cycles.
  - LW: 4 cycles.
  - SW, BEQZ, J, LI, MOV: 3 cycles.
  - Illegal opcode: 2 cycles.

Decomposition:
- Package proc_pkg:
  - State enum: FETCH, DECODE, EXEC, MEM_RD, MEM_WR, WB_ACC, WB_REG, BRANCH, HALT.
  - Opcode constants, ALU_Op codes, WB_Src codes, ACC_ADDR.
- One sub-module, mem_wait_timer: the counter, with inputs req/ack/clear and output timeout.

Test Plan:
- Reset_n=0 for 2 edges while Mem_Ack=1 → all outputs 0; after release, FSM is in FETCH and Mem_Read=1 in the next cycle.
- Opcode=0 (ADD), Mem_Ack tied high → FETCH(IR_Write, PC_Write), DECODE(Awrite, Bwrite), EXEC(ALUOut_Write, ALU_Op=0), WB_ACC(reg_write, write_address=F, iszero_write); 4 cycles total.
- LW, Mem_Ack delayed 3 cycles in MEM_RD → Mem_Read held high for 4 cycles; WB_ACC follows with WB_Src=1; no glitch on Mem_Write.
- BEQZ with Is_Zero=0, then a second BEQZ with Is_Zero=1 → PC_Write=0, then PC_Write=1 with PC_Src=1; each BRANCH lasts one cycle.
- Opcode=B (illegal) → Illegal pulses exactly 1 cycle in DECODE, no reg_write, back to FETCH; then Opcode=F → Halted=1 and stays high for 20 cycles regardless of inputs.
- Mem_Ack held 0 in FETCH → after 255 cycles Bus_Error=1, Mem_Read=0, Halted=1; Reset_n=0 for one edge clears Bus_Error and returns to FETCH.
